// File: rtl/jk_drive_sequencer.sv
// jk_drive_sequencer: plays a {J,K} step table into a JK flip-flop and counts Q mismatches
// against an internal reference model.
module jk_drive_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW = 4,
  parameter int HOLD = 1,
  parameter int ERR_W = 8
) (
  input  logic             Clk,
  input  logic             RST,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [1:0]       wr_jk,
  input  logic [AW:0]      len,
  input  logic             start,
  input  logic             q_fb,
  output logic             J,
  output logic             K,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    step,
  output logic [ERR_W-1:0] err_cnt
);
  localparam int HW = HOLD > 1 ? $clog2(HOLD) : 1;
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, CHECK, DONE} state_t;
  state_t state, nstate;
  logic [1:0] tbl [DEPTH];
  logic [HW-1:0] hcnt;
  logic [AW:0] run_len;
  logic [AW-1:0] nstep;
  logic q_exp, go, last_hold, last_step, nj, nk, nbusy, ndone;
  assign go = state == IDLE && start;
  assign last_hold = hcnt == HW'(HOLD - 1);
  assign last_step = {1'b0, step} + 1'b1 == run_len;
  always_ff @(posedge Clk or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      {J, K, busy, done} <= 4'b0000;
      step <= '0;
      hcnt <= '0;
      run_len <= '0;
      q_exp <= 1'b0;
      err_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) tbl[i] <= 2'b00;
    end else begin
      state <= nstate;
      {J, K, busy, done} <= {nj, nk, nbusy, ndone};
      step <= nstep;
      hcnt <= state == RUN && !last_hold ? hcnt + 1'b1 : '0;
      if (state == IDLE && wr_en) tbl[wr_addr] <= wr_jk;
      if (go) run_len <= len > (AW+1)'(DEPTH) ? (AW+1)'(DEPTH) : len;
      // reference FF follows the J/K that was on the wire during the cycle just ending
      if (state == CLEAR || state == RUN) q_exp <= J & K ? ~q_exp : J | K ? J : q_exp;
      if (go) err_cnt <= '0;
      else if ((state == RUN || state == CHECK) && q_fb != q_exp && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
    end
  end
  always_comb begin
    nstate = state;
    nstep = go ? '0 : state == RUN && last_hold && !last_step ? step + 1'b1 : step;
    case (state)
      IDLE:    nstate = start ? CLEAR : IDLE;
      CLEAR:   nstate = run_len != 0 ? RUN : CHECK;
      RUN:     nstate = last_hold && last_step ? CHECK : RUN;
      CHECK:   nstate = DONE;
      default: nstate = IDLE;
    endcase
  end
  always_comb begin
    {nj, nk} = nstate == CLEAR ? 2'b01 : nstate == RUN ? tbl[nstep] : 2'b00;
    nbusy = nstate == CLEAR || nstate == RUN || nstate == CHECK;
    ndone = nstate == DONE;
  end
endmodule

// File: tb/tb_jk_drive_sequencer.sv
// tb_jk_drive_sequencer: three sequencer instances (HOLD/ERR_W variants), each driving a
// behavioural JK flip-flop, checked every cycle against a schedule-based model.
module tb_jk_drive_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [1:0] wr_jk = '0;
  logic [4:0] len = '0;
  logic [2:0] start = '0;
  logic [1:0] mode [3] = '{2'd0, 2'd0, 2'd0};
  logic [2:0] ff = '0;
  logic [2:0] q_fb;
  logic [2:0] dj, dk, db, dd;
  logic [3:0] ds [3];
  logic [7:0] de [3];
  logic [1:0] e6;
  int checks = 0;
  int errors = 0;
  int H [3] = '{1, 3, 1};
  int EM [3] = '{255, 255, 3};
  bit act [3];
  int k [3], ln [3], stp [3], er [3];
  logic qx [3];
  logic [1:0] tb [3][16];
  always #5 clk = ~clk;
  jk_drive_sequencer #(.HOLD(1)) u1 (.Clk(clk), .RST(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_jk(wr_jk),
    .len(len), .start(start[0]), .q_fb(q_fb[0]), .J(dj[0]), .K(dk[0]), .busy(db[0]), .done(dd[0]),
    .step(ds[0]), .err_cnt(de[0]));
  jk_drive_sequencer #(.HOLD(3)) u3 (.Clk(clk), .RST(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_jk(wr_jk),
    .len(len), .start(start[1]), .q_fb(q_fb[1]), .J(dj[1]), .K(dk[1]), .busy(db[1]), .done(dd[1]),
    .step(ds[1]), .err_cnt(de[1]));
  jk_drive_sequencer #(.HOLD(1), .ERR_W(2)) u6 (.Clk(clk), .RST(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_jk(wr_jk), .len(len), .start(start[2]), .q_fb(q_fb[2]), .J(dj[2]), .K(dk[2]), .busy(db[2]),
    .done(dd[2]), .step(ds[2]), .err_cnt(e6));
  assign de[2] = {6'd0, e6};
  function automatic logic jkn(input logic q, input logic [1:0] jk);
    case (jk)
      2'b00: return q;
      2'b01: return 1'b0;
      2'b10: return 1'b1;
      default: return ~q;
    endcase
  endfunction
  // downstream flip-flop (no reset) and the q_fb fault modes: 0 real, 1 stuck 0, 2 inverted
  always @(posedge clk) for (int i = 0; i < 3; i++) ff[i] <= jkn(ff[i], {dj[i], dk[i]});
  always_comb for (int i = 0; i < 3; i++) q_fb[i] = mode[i] == 2'd0 ? ff[i] : mode[i] == 2'd1 ? 1'b0 : ~ff[i];
  function automatic logic [1:0] ejk(input int i);
    if (!act[i]) return 2'b00;
    if (k[i] == 0) return 2'b01;
    if (k[i] <= ln[i] * H[i]) return tb[i][(k[i] - 1) / H[i]];
    return 2'b00;
  endfunction
  // model: k counts cycles since an accepted start; 0 = clear, 1..len*HOLD = steps, then check, done
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        act[i] = 0; k[i] = 0; ln[i] = 0; stp[i] = 0; er[i] = 0; qx[i] = 0;
        for (int a = 0; a < 16; a++) tb[i][a] = 2'b00;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (act[i]) begin
          if (k[i] >= 1 && k[i] <= ln[i] * H[i] + 1 && q_fb[i] !== qx[i]) er[i] = er[i] < EM[i] ? er[i] + 1 : er[i];
          if (k[i] <= ln[i] * H[i]) qx[i] = jkn(qx[i], ejk(i));
          if (k[i] == ln[i] * H[i] + 2) act[i] = 0;
          else begin
            k[i]++;
            if (k[i] >= 1 && k[i] <= ln[i] * H[i]) stp[i] = (k[i] - 1) / H[i];
          end
        end else begin
          if (wr_en) tb[i][wr_addr] = wr_jk;
          if (start[i]) begin
            act[i] = 1; k[i] = 0; ln[i] = len > 16 ? 16 : int'(len); er[i] = 0; stp[i] = 0;
          end
        end
      end
    end
  end
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic [1:0] e;
      e = ejk(i);
      chk($sformatf("u%0d_J", i), int'(dj[i]), int'(e[1]));
      chk($sformatf("u%0d_K", i), int'(dk[i]), int'(e[0]));
      chk($sformatf("u%0d_busy", i), int'(db[i]), int'(act[i] && k[i] <= ln[i] * H[i] + 1));
      chk($sformatf("u%0d_done", i), int'(dd[i]), int'(act[i] && k[i] == ln[i] * H[i] + 2));
      chk($sformatf("u%0d_step", i), int'(ds[i]), stp[i]);
      chk($sformatf("u%0d_err", i), int'(de[i]), er[i]);
    end
  end
  task automatic load(input logic [1:0] v [6]);
    for (int a = 0; a < 6; a++) begin
      @(negedge clk);
      wr_en = 1; wr_addr = 4'(a); wr_jk = v[a];
    end
    @(negedge clk);
    wr_en = 0;
  endtask
  task automatic go(input int i, input int l, input bit we, input bit poke,
                    output int n, output int nb, output int seq, output int tog);
    logic prev;
    bit fin;
    @(negedge clk);
    len = 5'(l); start[i] = 1;
    if (we) begin wr_en = 1; wr_addr = 0; wr_jk = 2'b11; end
    @(negedge clk);
    start[i] = 0; wr_en = 0;
    n = 0; nb = int'(db[i]); seq = 0; tog = 0; prev = ff[i]; fin = 0;
    while (!fin && n < 100) begin
      @(negedge clk);
      n++;
      if (poke) start[i] = n == 2;
      if (db[i]) nb++;
      if (n >= 2 && db[i]) seq = seq * 2 + int'(ff[i]);
      if (n >= 2 && db[i] && ff[i] != prev) tog++;
      prev = ff[i];
      if (dd[i]) fin = 1;
    end
    start[i] = 0;
    if (!fin) chk("done_timeout", 0, 1);
  endtask
  initial begin
    int n, nb, seq, tog;
    logic [1:0] t2 [6] = '{2'b00, 2'b01, 2'b11, 2'b11, 2'b10, 2'b00};
    repeat (2) @(negedge clk);
    rst = 0;
    chk("reset_busy", int'(db[0]), 0);
    chk("reset_err", int'(de[0]), 0);
    load(t2);
    go(0, 6, 0, 0, n, nb, seq, tog);
    chk("t2_done_cycle", n, 8);
    chk("t2_busy_cycles", nb, 8);
    chk("t2_q_seq", seq, 'b001011);
    chk("t2_err", int'(de[0]), 0);
    mode[0] = 2'd1;
    go(0, 6, 0, 0, n, nb, seq, tog);
    chk("t3_err", int'(de[0]), 3);
    mode[0] = 2'd0;
    go(0, 0, 0, 0, n, nb, seq, tog);
    chk("t4_done_cycle", n, 2);
    chk("t4_busy_cycles", nb, 2);
    chk("t4_err", int'(de[0]), 0);
    go(1, 1, 1, 1, n, nb, seq, tog);
    chk("t5_done_cycle", n, 5);
    chk("t5_toggles", tog, 3);
    chk("t5_err", int'(de[1]), 0);
    mode[1] = 2'd2;
    go(1, 1, 0, 0, n, nb, seq, tog);
    chk("t5_inv_err", int'(de[1]), 4);
    mode[1] = 2'd0;
    mode[2] = 2'd2;
    go(2, 5, 0, 0, n, nb, seq, tog);
    chk("t6_sat_err", int'(de[2]), 3);
    @(negedge clk);
    len = 6; start[2] = 1;
    @(negedge clk);
    start[2] = 0;
    repeat (3) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("t1_async_J", int'(dj[2]), 0);
    chk("t1_async_K", int'(dk[2]), 0);
    chk("t1_async_busy", int'(db[2]), 0);
    chk("t1_async_err", int'(de[2]), 0);
    chk("t1_async_step", int'(ds[2]), 0);
    @(negedge clk);
    rst = 0; mode[2] = 2'd0;
    go(2, 6, 0, 0, n, nb, seq, tog);
    chk("t6_cleared_seq", seq, 0);
    chk("t6_cleared_busy", nb, 8);
    chk("t6_cleared_err", int'(de[2]), 0);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
